seletor_velocidade: RTL and testbench

- Parametrised speed selector driving the toy's action sequencer.
- Two active-low push buttons (mais/menos) are synchronised and counter-debounced. Each press steps a speed level up or down.
- The block generates the action-rate tick whose period depends on the level.
- It pulses reset_contagem_botao on every level change so downstream counters restart cleanly.

---
 rtl/seletor_velocidade_pkg.sv | 14 +
 rtl/seletor_velocidade_debounce.sv | 47 ++++
 rtl/seletor_velocidade.sv | 85 ++++++++
 tb/tb_seletor_velocidade.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seletor_velocidade_pkg.sv
// Shared constants and the level-to-period mapping for the speed selector.
package pkg_velocidade;

  localparam int unsigned MODO_CIRCULAR = 0;
  localparam int unsigned MODO_SATURA   = 1;

  // Tick period in clk cycles: a higher level gives a shorter period.
  function automatic int unsigned periodo_nivel(input int unsigned periodo_base,
                                                input int unsigned num_niveis,
                                                input int unsigned nivel);
    return periodo_base * (num_niveis - nivel);
  endfunction

endpackage

// File: rtl/seletor_velocidade_debounce.sv
// Two-flop synchroniser plus counter debounce for one active-low button.
// Emits a one-cycle pulse on each accepted press (released -> pressed).
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CICLOS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic botao,
  output logic pressionado
);

  localparam int unsigned LARGURA_CONT = $clog2(DEBOUNCE_CICLOS + 1);

  logic                    s1;
  logic                    s2;
  logic                    estavel;
  logic                    estavel_d;
  logic [LARGURA_CONT-1:0] cont;

  // Synchronise, count stable disagreement, and register the press edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      estavel     <= 1'b1;
      estavel_d   <= 1'b1;
      cont        <= '0;
      pressionado <= 1'b0;
    end else begin
      s1          <= botao;
      s2          <= s1;
      estavel_d   <= estavel;
      pressionado <= estavel_d & ~estavel;
      if (s2 != estavel) begin
        if (cont == LARGURA_CONT'(DEBOUNCE_CICLOS - 1)) begin
          estavel <= s2;
          cont    <= '0;
        end else begin
          cont <= cont + LARGURA_CONT'(1);
        end
      end else begin
        cont <= '0;
      end
    end
  end

endmodule

// File: rtl/seletor_velocidade.sv
// Speed selector: debounced up/down buttons step a level that sets the
// action-rate tick period; each level change pulses reset_contagem_botao.
module seletor_velocidade #(
  parameter int unsigned NUM_NIVEIS      = 4,
  parameter int unsigned LARGURA_NIVEL   = $clog2(NUM_NIVEIS),
  parameter int unsigned DEBOUNCE_CICLOS = 16,
  parameter int unsigned PERIODO_BASE    = 25000000,
  parameter int unsigned MODO_SATURA     = 0,
  parameter int unsigned NIVEL_INICIAL   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     botao_mais,
  input  logic                     botao_menos,
  output logic [LARGURA_NIVEL-1:0] nivel,
  output logic                     reset_contagem_botao,
  output logic                     tick
);

  import pkg_velocidade::*;

  localparam int unsigned LARGURA_CONT = $clog2(PERIODO_BASE * NUM_NIVEIS);
  localparam logic [LARGURA_NIVEL-1:0] NIVEL_MAX = LARGURA_NIVEL'(NUM_NIVEIS - 1);
  localparam bit SATURA = (MODO_SATURA == pkg_velocidade::MODO_SATURA);

  logic                     pulso_mais;
  logic                     pulso_menos;
  logic [LARGURA_NIVEL-1:0] nivel_prox_c;
  logic                     muda_c;
  logic [LARGURA_CONT-1:0]  cont;
  logic [LARGURA_CONT-1:0]  cont_fim_c;

  debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_mais (
    .clk         (clk),
    .reset       (reset),
    .botao       (botao_mais),
    .pressionado (pulso_mais)
  );

  debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_menos (
    .clk         (clk),
    .reset       (reset),
    .botao       (botao_menos),
    .pressionado (pulso_menos)
  );

  // Next level from the press pulses; simultaneous presses cancel out.
  always_comb begin
    nivel_prox_c = nivel;
    if (pulso_mais && !pulso_menos) begin
      if (nivel == NIVEL_MAX) nivel_prox_c = SATURA ? nivel : '0;
      else                    nivel_prox_c = nivel + LARGURA_NIVEL'(1);
    end else if (pulso_menos && !pulso_mais) begin
      if (nivel == '0) nivel_prox_c = SATURA ? nivel : NIVEL_MAX;
      else             nivel_prox_c = nivel - LARGURA_NIVEL'(1);
    end
    muda_c = (nivel_prox_c != nivel);
  end

  assign cont_fim_c = LARGURA_CONT'(periodo_nivel(PERIODO_BASE, NUM_NIVEIS, 32'(nivel)) - 1);

  // Level register and tick counter; a level change restarts the cadence.
  always_ff @(posedge clk) begin
    if (reset) begin
      nivel                <= LARGURA_NIVEL'(NIVEL_INICIAL);
      reset_contagem_botao <= 1'b0;
      cont                 <= '0;
      tick                 <= 1'b0;
    end else begin
      nivel                <= nivel_prox_c;
      reset_contagem_botao <= muda_c;
      if (muda_c) begin
        cont <= '0;
        tick <= 1'b0;
      end else if (cont == cont_fim_c) begin
        cont <= '0;
        tick <= 1'b1;
      end else begin
        cont <= cont + LARGURA_CONT'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seletor_velocidade.sv
// Directed bench for seletor_velocidade: one wrapping and one saturating
// instance share the same stimulus and are checked against hand values.
module tb_seletor_velocidade;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       botao_mais = 1'b1;
  logic       botao_menos = 1'b1;
  logic [1:0] nivel_w, nivel_s;
  logic       rcb_w, rcb_s;
  logic       tick_w, tick_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seletor_velocidade #(
    .NUM_NIVEIS(4), .DEBOUNCE_CICLOS(4), .PERIODO_BASE(5),
    .MODO_SATURA(0), .NIVEL_INICIAL(0)
  ) dut_w (
    .clk(clk), .reset(reset), .botao_mais(botao_mais), .botao_menos(botao_menos),
    .nivel(nivel_w), .reset_contagem_botao(rcb_w), .tick(tick_w)
  );

  seletor_velocidade #(
    .NUM_NIVEIS(4), .DEBOUNCE_CICLOS(4), .PERIODO_BASE(5),
    .MODO_SATURA(1), .NIVEL_INICIAL(0)
  ) dut_s (
    .clk(clk), .reset(reset), .botao_mais(botao_mais), .botao_menos(botao_menos),
    .nivel(nivel_s), .reset_contagem_botao(rcb_s), .tick(tick_s)
  );

  // Two reset edges; returns 1ns after the last one with reset released.
  task automatic do_reset();
    botao_mais  = 1'b1;
    botao_menos = 1'b1;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Press for 12 cycles then release for 12, counting level-change pulses.
  task automatic apertar(input logic mais, input logic menos,
                         output int pw, output int ps);
    pw = 0;
    ps = 0;
    botao_mais  = ~mais;
    botao_menos = ~menos;
    for (int k = 0; k < 24; k++) begin
      if (k == 12) begin
        botao_mais  = 1'b1;
        botao_menos = 1'b1;
      end
      @(posedge clk);
      #1;
      pw += int'(rcb_w);
      ps += int'(rcb_s);
    end
  endtask

  task automatic test_reset();
    logic exp_t;
    do_reset();
    checks++; if (nivel_w !== 2'd0) begin failures++; $display("FAIL reset_nivel_w got=%0d exp=0", nivel_w); end
    checks++; if (nivel_s !== 2'd0) begin failures++; $display("FAIL reset_nivel_s got=%0d exp=0", nivel_s); end
    checks++; if (rcb_w !== 1'b0) begin failures++; $display("FAIL reset_rcb_w got=%b exp=0", rcb_w); end
    checks++; if (tick_w !== 1'b0) begin failures++; $display("FAIL reset_tick_w got=%b exp=0", tick_w); end
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      exp_t = (k == 20) || (k == 40);
      checks++; if (tick_w !== exp_t) begin failures++; $display("FAIL tick_cadence_w k=%0d got=%b exp=%b", k, tick_w, exp_t); end
      checks++; if (tick_s !== exp_t) begin failures++; $display("FAIL tick_cadence_s k=%0d got=%b exp=%b", k, tick_s, exp_t); end
    end
  endtask

  task automatic test_step_latency();
    logic [1:0] exp_n;
    logic       exp_r;
    logic       exp_t;
    do_reset();
    botao_mais = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      exp_n = (k >= 7) ? 2'd1 : 2'd0;
      exp_r = (k == 7);
      exp_t = (k == 22);
      checks++; if (nivel_w !== exp_n) begin failures++; $display("FAIL step_nivel k=%0d got=%0d exp=%0d", k, nivel_w, exp_n); end
      checks++; if (rcb_w !== exp_r) begin failures++; $display("FAIL step_rcb k=%0d got=%b exp=%b", k, rcb_w, exp_r); end
      checks++; if (tick_w !== exp_t) begin failures++; $display("FAIL step_tick k=%0d got=%b exp=%b", k, tick_w, exp_t); end
    end
    botao_mais = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (nivel_s !== 2'd1) begin failures++; $display("FAIL step_hold_nivel got=%0d exp=1", nivel_s); end
  endtask

  task automatic test_bounce();
    logic exp_t;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      botao_mais = (k == 2 || k >= 6) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      exp_t = (k == 19) || (k == 39);
      checks++; if (nivel_w !== 2'd0) begin failures++; $display("FAIL bounce_nivel k=%0d got=%0d exp=0", k, nivel_w); end
      checks++; if (rcb_w !== 1'b0) begin failures++; $display("FAIL bounce_rcb k=%0d got=%b exp=0", k, rcb_w); end
      checks++; if (tick_w !== exp_t) begin failures++; $display("FAIL bounce_tick k=%0d got=%b exp=%b", k, tick_w, exp_t); end
    end
  endtask

  task automatic test_wrap_saturate();
    int pw, ps;
    do_reset();
    apertar(1'b0, 1'b1, pw, ps);
    checks++; if (nivel_w !== 2'd3 || pw != 1) begin failures++; $display("FAIL menos_wrap got=%0d/%0d exp=3/1", nivel_w, pw); end
    checks++; if (nivel_s !== 2'd0 || ps != 0) begin failures++; $display("FAIL menos_sat got=%0d/%0d exp=0/0", nivel_s, ps); end
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      apertar(1'b1, 1'b0, pw, ps);
      checks++; if (nivel_w !== 2'(i) || pw != 1) begin failures++; $display("FAIL mais_w i=%0d got=%0d/%0d exp=%0d/1", i, nivel_w, pw, i); end
      checks++; if (nivel_s !== 2'(i) || ps != 1) begin failures++; $display("FAIL mais_s i=%0d got=%0d/%0d exp=%0d/1", i, nivel_s, ps, i); end
    end
    apertar(1'b1, 1'b0, pw, ps);
    checks++; if (nivel_w !== 2'd0 || pw != 1) begin failures++; $display("FAIL mais_wrap got=%0d/%0d exp=0/1", nivel_w, pw); end
    checks++; if (nivel_s !== 2'd3 || ps != 0) begin failures++; $display("FAIL mais_sat got=%0d/%0d exp=3/0", nivel_s, ps); end
  endtask

  task automatic test_simultaneous();
    int pw, ps;
    do_reset();
    apertar(1'b1, 1'b0, pw, ps);
    apertar(1'b1, 1'b1, pw, ps);
    checks++; if (nivel_w !== 2'd1 || pw != 0) begin failures++; $display("FAIL both_w got=%0d/%0d exp=1/0", nivel_w, pw); end
    checks++; if (nivel_s !== 2'd1 || ps != 0) begin failures++; $display("FAIL both_s got=%0d/%0d exp=1/0", nivel_s, ps); end
  endtask

  task automatic test_reset_mid_debounce();
    int pw, ps;
    logic [1:0] exp_n;
    logic       exp_r;
    do_reset();
    apertar(1'b1, 1'b0, pw, ps);
    apertar(1'b1, 1'b0, pw, ps);
    botao_menos = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++; if (nivel_w !== 2'd2) begin failures++; $display("FAIL mid_pre k=%0d got=%0d exp=2", k, nivel_w); end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (nivel_w !== 2'd0 || rcb_w !== 1'b0) begin failures++; $display("FAIL mid_reset_w got=%0d/%b exp=0/0", nivel_w, rcb_w); end
    checks++; if (nivel_s !== 2'd0 || rcb_s !== 1'b0) begin failures++; $display("FAIL mid_reset_s got=%0d/%b exp=0/0", nivel_s, rcb_s); end
    for (int k = 5; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_n = (k >= 12) ? 2'd3 : 2'd0;
      exp_r = (k == 12);
      checks++; if (nivel_w !== exp_n || rcb_w !== exp_r) begin failures++; $display("FAIL mid_w k=%0d got=%0d/%b exp=%0d/%b", k, nivel_w, rcb_w, exp_n, exp_r); end
      checks++; if (nivel_s !== 2'd0 || rcb_s !== 1'b0) begin failures++; $display("FAIL mid_s k=%0d got=%0d/%b exp=0/0", k, nivel_s, rcb_s); end
    end
    botao_menos = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_step_latency();
    test_bounce();
    test_wrap_saturate();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
